// File: rtl/lamp_shift_if.sv
// lamp_shift_if: bundle between the flasher core / board side and the
// lamp shift driver.
//   lamp        core -> driver, lamp vector (MSB shifted first)
//   ser_data    driver -> LED chain, serial data
//   ser_clk     driver -> LED chain, shift clock (sampled on rising edge)
//   ser_latch   driver -> LED chain, storage latch pulse
//   busy        driver status, frame in progress
//   frame_done  driver status, one-cycle pulse after each frame
// master = the side that owns lamp, slave = the shift driver.
interface lamp_shift_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] lamp;
    logic             ser_data;
    logic             ser_clk;
    logic             ser_latch;
    logic             busy;
    logic             frame_done;

    modport master (
        output lamp,
        input  ser_data, ser_clk, ser_latch, busy, frame_done
    );

    modport slave (
        input  lamp,
        output ser_data, ser_clk, ser_latch, busy, frame_done
    );
endinterface

// File: rtl/lamp_shift_driver.sv
// lamp_shift_driver: serialises the flasher lamp vector into a chain of
// 74HC595-style SIPO registers, MSB first. A frame is sent whenever lamp
// differs from the last value sent, and once after every reset.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    lamp_shift_if.slave (lamp in; ser_data/ser_clk/ser_latch,
//          busy, frame_done out). All outputs come straight from flops.
// Parameters:
//   WIDTH  lamp bits per frame (>= 2)
//   DIV    clk cycles per ser_clk low phase, high phase and latch pulse (>= 1)
module lamp_shift_driver #(
    parameter int WIDTH = 16,
    parameter int DIV   = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    lamp_shift_if.slave   bus
);
    localparam int BW = $clog2(WIDTH);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             init_q, init_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [DW-1:0]    div_q, div_d;
    logic             data_q, data_d;
    logic             sclk_q, sclk_d;
    logic             latch_q, latch_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            shadow_q <= '0;
            init_q   <= 1'b1;
            bit_q    <= '0;
            div_q    <= '0;
            data_q   <= 1'b0;
            sclk_q   <= 1'b0;
            latch_q  <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            shadow_q <= shadow_d;
            init_q   <= init_d;
            bit_q    <= bit_d;
            div_q    <= div_d;
            data_q   <= data_d;
            sclk_q   <= sclk_d;
            latch_q  <= latch_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    // Next-state and next-output logic. Outputs are computed one step ahead
    // and registered so the pins see only flop outputs.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        shadow_d = shadow_q;
        init_d   = init_q;
        bit_d    = bit_q;
        div_d    = div_q;
        data_d   = data_q;
        sclk_d   = sclk_q;
        latch_d  = latch_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                // Latest lamp value only; anything that changed during the
                // previous frame collapses into this one comparison.
                if ((bus.lamp != shadow_q) || init_q) begin
                    shift_d  = bus.lamp;
                    shadow_d = bus.lamp;
                    init_d   = 1'b0;
                    bit_d    = BIT_LAST;
                    div_d    = DIV_LAST;
                    data_d   = bus.lamp[WIDTH-1];
                    sclk_d   = 1'b0;
                    state_d  = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                if (div_q == '0) begin
                    div_d   = DIV_LAST;
                    sclk_d  = 1'b1;
                    state_d = SHIFT_HI;
                end else begin
                    div_d = div_q - 1'b1;
                end
            end
            SHIFT_HI: begin
                if (div_q == '0) begin
                    div_d  = DIV_LAST;
                    sclk_d = 1'b0;
                    if (bit_q == '0) begin
                        latch_d = 1'b1;
                        state_d = LATCH;
                    end else begin
                        // Data changes together with the falling ser_clk edge,
                        // a full low phase ahead of the next sampling edge.
                        shift_d = {shift_q[WIDTH-2:0], 1'b0};
                        data_d  = shift_q[WIDTH-2];
                        bit_d   = bit_q - 1'b1;
                        state_d = SHIFT_LO;
                    end
                end else begin
                    div_d = div_q - 1'b1;
                end
            end
            LATCH: begin
                if (div_q == '0) begin
                    latch_d = 1'b0;
                    data_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    div_d = div_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    assign bus.ser_data   = data_q;
    assign bus.ser_clk    = sclk_q;
    assign bus.ser_latch  = latch_q;
    assign bus.frame_done = done_q;
    assign bus.busy       = busy_q;
endmodule

// File: doc/lamp_shift_driver.md
Name: lamp_shift_driver

Overview:
- Downstream stage of the bound-flasher core: consumes the 16-bit lamp vector and drives an external chain of serial-in/parallel-out LED registers (74HC595-style, MSB first) over three wires.
- Sends a frame only when lamp differs from the last value sent, plus one frame after every reset.
- Board LEDs therefore track the core's lamp output.

Parameters:
- WIDTH, 16, number of lamp bits serialised per frame.
- DIV, 2, clk cycles per ser_clk phase (low phase, high phase, latch pulse); minimum 1.

Ports:
- clk  input  1  system clock, all logic on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- lamp  input  WIDTH  lamp vector from the flasher core; lamp[WIDTH-1] is shifted first.
- ser_data  output  1  serial data to the LED register chain.
- ser_clk  output  1  shift clock; the external register samples on its rising edge.
- ser_latch  output  1  storage-register latch pulse, active high.
- busy  output  1  high while a frame is in progress.
- frame_done  output  1  one-cycle pulse after each completed frame.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - ser_data, ser_clk, ser_latch, busy and frame_done are 0.
  - State is IDLE; shadow (last-sent value), shift register and counters are 0.
  - init_pending is 1.
  - Reset asserted mid-frame aborts the frame immediately; no latch pulse is issued.
- States: IDLE, SHIFT_LO, SHIFT_HI, LATCH. busy=1 in every state except IDLE, and comes from the registered state.
- IDLE:
  - Outputs held at 0.
  - At a rising edge where (lamp != shadow) or init_pending, the block captures lamp into the shift register and shadow, clears init_pending, loads bit_cnt=WIDTH-1 and div_cnt=DIV-1, drives ser_data=lamp[WIDTH-1], and moves to SHIFT_LO.
- SHIFT_LO:
  - ser_clk=0 for DIV cycles with ser_data stable, then move to SHIFT_HI.
- SHIFT_HI:
  - ser_clk=1 for DIV cycles with ser_data unchanged while ser_clk is high.
  - At exit, if bit_cnt==0, go to LATCH.
  - Otherwise shift left, put the next bit on ser_data, decrement bit_cnt and go to SHIFT_LO.
- LATCH:
  - ser_clk=0 and ser_latch=1 for DIV cycles, then go to IDLE.
  - frame_done=1 for exactly the first IDLE cycle.
- Frame timing: busy is high for WIDTH*2*DIV + DIV cycles, which is 66 cycles at the defaults.
- Capture latency: one clock from the lamp change to the capture edge, measured from the edge that first sees the new value while in IDLE.
- lamp changes during a frame:
  - They are ignored until the frame completes; the frame in flight is never corrupted.
  - After the frame, the value present in IDLE is compared with shadow; only the latest value is sent, and intermediate values are dropped.
- Back-to-back frames: the capture edge may be the same edge at which frame_done is asserted. The minimum IDLE gap is 1 cycle.
- lamp equal to shadow and init_pending=0: the block stays in IDLE indefinitely with no ser_clk activity.
- Counters:
  - bit_cnt is $clog2(WIDTH) bits wide.
  - div_cnt is max($clog2(DIV),1) bits wide; its terminal count is 0.
  - No wrap is permitted beyond the terminal count.
- All outputs are driven directly from flops; no combinational glitches reach the pins.

Test Plan:
- Reset then release with lamp=16'h0000 -> one init frame; 16 zero bits sampled on ser_clk rising edges; busy high for 66 cycles; ser_latch high for 2 cycles; frame_done a single 1-cycle pulse; afterwards no further ser_clk edges for 200 cycles.
- lamp steps 16'h0000 -> 16'h001f in IDLE -> capture one clock later; bits captured on ser_clk rising edges read 11 zeros then 5 ones; the bench shift-register model equals 16'h001f at the rising edge of ser_latch.
- Mid-frame change: lamp=16'h0003 starts a frame, then 16'h0007 then 16'h000f arrive while busy -> first frame delivers 16'h0003, then exactly one more frame delivers 16'h000f; 16'h0007 is never sent.
- Reset asserted at bit 8 of a 16'hffff frame -> all outputs 0 without waiting for a clock edge, no ser_latch pulse; after release, an init frame sends the current lamp value even if it equals 16'hffff.
- Lamp sequence of the bound-flasher run (16'h0000, 16'h0001, 16'h0003 ... 16'h007f) changing every 80 cycles -> one frame per change; the model's latched value matches each lamp value in order, and the frame_done count equals the number of changes plus 1.
- DIV=1 build with lamp=16'ha5a5 -> busy high for 33 cycles, ser_clk toggling every cycle, latched value 16'ha5a5.
